rpe_weight_encoder_loader: RTL and testbench
============================================

# rpe_weight_encoder_loader

Weight-side feeder for the RPE systolic array. Accepts a stream of 8-bit unsigned weights and encodes each into the 5-bit RPE weight format. It packs one row of SIZE encoded weights and drives it into the top of the array with a one-cycle weight-valid pulse, repeating until SIZE rows are loaded. It is the producer for the array's `Weight_in`/`Weight_in_valid` path and the encoder counterpart of the RPE MAC decode.

## Interface
- `SIZE`, default 8: array dimension (columns per row and rows per tile).
- `CNT_W`, default `$clog2(SIZE*SIZE+1)`: width of the lossy-encode counter.

- `clk`  in  1  clock. One clock domain; all registers update on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a tile load. Sampled only in IDLE.
- `w_valid`  in  1  upstream weight valid.
- `w_ready`  out  1  loader can accept a weight.
- `w_data`  in  8  unsigned weight.
- `Weight_out`  out  SIZE*5  encoded row. Column c is at bits [5c+4:5c].
- `Weight_out_valid`  out  1  row valid. Connects to the array's `Weight_in_valid`.
- `busy`  out  1  high in COLLECT and ISSUE.
- `done`  out  1  one-cycle pulse when the tile is complete.
- `lossy_cnt`  out  CNT_W  count of inexact encodes in the current tile. Saturates at its maximum value.

## Operation
- The 5-bit format has two cases:
  - bit4=1 (MSR4): decoded value = 16·n, where n = bits[3:0].
  - bit4=0: decoded value = 2·n+1.
- Encoding of w:
  - w[3:0]==0 (includes 0): emit {1, w[7:4]}. Exact.
  - else if w≤31: emit {0, w[4:1]}. Exact iff w[0]=1; otherwise lossy, and the decoded value is w+1.
  - else: m = min((w+8)>>4, 15); emit {1, m[3:0]}. Lossy.
- A weight is accepted on any edge where `w_valid && w_ready`. Its encoding goes into slot `col_cnt` of the row register, then `col_cnt` increments.
- The first weight of a row is column 0.
- Upstream supplies rows bottom-first, because rows shift downward through the array.
- `lossy_cnt` increments by 1 per accepted lossy weight, saturating at 2^CNT_W−1. It clears on the edge that accepts `start` in IDLE.
- FSM transitions:
  - IDLE: `w_ready`=0. On `start` → COLLECT; clear `col_cnt`, `row_cnt` and `lossy_cnt`.
  - COLLECT: `w_ready`=1. On the SIZE-th accept (`col_cnt`==SIZE−1) → ISSUE.
  - ISSUE: `Weight_out_valid`=1 for exactly one cycle, with `Weight_out` holding the completed row. If `row_cnt`==SIZE−1 → DONE; otherwise increment `row_cnt`, clear `col_cnt`, → COLLECT.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` is ignored in COLLECT, ISSUE and DONE.
- `w_valid` outside COLLECT is ignored; no weight is consumed.
- `Weight_out` holds its last value outside ISSUE. Only `Weight_out_valid` qualifies it.

## Timing
- Reset values: state IDLE; `w_ready`=0; `Weight_out`=0; `Weight_out_valid`=0; `busy`=0; `done`=0; `lossy_cnt`=0; counters=0.
- `rst` takes priority over all other inputs, including mid-COLLECT and mid-ISSUE. A partial row is discarded and no valid pulse is emitted.
- All outputs are registered or decoded directly from state. There is no combinational path from `w_valid` or `w_data` to any output.
- `start` sampled at edge 0 → `w_ready`=1 from cycle 1.
- SIZE-th accept at edge k → `Weight_out_valid`=1 during cycle k+1 only.
  - The next row's first accept can occur at edge k+2.
- With `w_valid` held high, a full tile takes SIZE·(SIZE+1) cycles from the first accept to the final ISSUE. `done` asserts one cycle after the final ISSUE.
- Exactly SIZE `Weight_out_valid` pulses and one `done` pulse per tile.

## Test plan
- **Reset:** assert `rst` for 2 cycles while driving `start`/`w_valid` → all outputs 0, state IDLE, no `Weight_out_valid`.
- **Exact encode (SIZE=8):**
  - Stimulus: row 0,16,240,1,31,17,3,144 → `Weight_out` columns 0..7 = 5'h10,5'h11,5'h1F,5'h00,5'h0F,5'h08,5'h01,5'h19.
  - Required response: `lossy_cnt`=0; a single `Weight_out_valid` pulse one cycle after the 8th accept.
- **Lossy encode:** weights 2, 40, 250, then 5×17 → columns 0..2 = 5'h01, 5'h13, 5'h1F; `lossy_cnt`=3.
- **Backpressure / full tile:**
  - Stimulus: 64 weights with `w_valid` toggling every cycle.
  - Required response: 8 ISSUE pulses, each only after its 8th accept; no weight lost or duplicated (compare against a model); `done` pulses once; `busy` falls with `done`.
- **Reset mid-row:** `rst` after 5 accepts in row 2 → IDLE, no pulse. A fresh `start` plus 8 new weights issues a row containing only the new weights, and `lossy_cnt` restarts from 0.
- **start handling:**
  - `start` held high throughout a tile → ignored while busy; a second tile begins only from IDLE after `done`.
  - `lossy_cnt` keeps its value after `done` until the next accepted `start`.

Source files
------------

// File: rtl/rpe_weight_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : rpe_weight_encoder_loader
// Purpose  : Encodes 8-bit weights into the 5-bit RPE format and loads one
//            SIZE x SIZE tile into the array row by row.
// Revision : 1.0 - initial release
// ============================================================================
module rpe_weight_encoder_loader #(
    parameter int SIZE  = 8,
    parameter int CNT_W = $clog2(SIZE*SIZE+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [7:0]          w_data,
    output logic [SIZE*5-1:0]   Weight_out,
    output logic                Weight_out_valid,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    lossy_cnt
);

    localparam int c_IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(SIZE-1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_ISSUE   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_col_cnt;
    logic [c_IDX_W-1:0]  r_row_cnt;
    logic [SIZE*5-1:0]   r_row;
    logic [SIZE*5-1:0]   r_weight_out;
    logic [CNT_W-1:0]    r_lossy_cnt;

    logic [5:0]          w_enc;
    logic [4:0]          w_code;
    logic                w_lossy;
    logic [SIZE*5-1:0]   w_row_next;

    // Returns {lossy, code}.
    function automatic logic [5:0] f_encode(input logic [7:0] w);
        logic [8:0] sum;
        logic [4:0] m;
        sum = {1'b0, w} + 9'd8;
        m   = sum[8:4];
        if (m > 5'd15) begin
            m = 5'd15;
        end
        if (w[3:0] == 4'd0) begin
            f_encode = {1'b0, 1'b1, w[7:4]};
        end else if (w <= 8'd31) begin
            f_encode = {~w[0], 1'b0, w[4:1]};
        end else begin
            f_encode = {1'b1, 1'b1, m[3:0]};
        end
    endfunction

    assign w_enc   = f_encode(w_data);
    assign w_code  = w_enc[4:0];
    assign w_lossy = w_enc[5];

    generate
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            assign w_row_next[5*c +: 5] = (r_col_cnt == c_IDX_W'(c)) ? w_code : r_row[5*c +: 5];
        end
    endgenerate

    assign w_ready          = (r_state == c_COLLECT);
    assign Weight_out_valid = (r_state == c_ISSUE);
    assign busy             = (r_state == c_COLLECT) || (r_state == c_ISSUE);
    assign done             = (r_state == c_DONE);
    assign Weight_out       = r_weight_out;
    assign lossy_cnt        = r_lossy_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_row        <= '0;
            r_weight_out <= '0;
            r_lossy_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_COLLECT;
                        r_col_cnt   <= '0;
                        r_row_cnt   <= '0;
                        r_lossy_cnt <= '0;
                    end
                end
                c_COLLECT: begin
                    if (w_valid) begin
                        r_row     <= w_row_next;
                        r_col_cnt <= r_col_cnt + c_IDX_W'(1);
                        if (w_lossy && (r_lossy_cnt != {CNT_W{1'b1}})) begin
                            r_lossy_cnt <= r_lossy_cnt + CNT_W'(1);
                        end
                        // Snapshot the completed row so the output stays stable while the next row fills.
                        if (r_col_cnt == c_LAST) begin
                            r_state      <= c_ISSUE;
                            r_weight_out <= w_row_next;
                            r_col_cnt    <= '0;
                        end
                    end
                end
                c_ISSUE: begin
                    if (r_row_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end else begin
                        r_row_cnt <= r_row_cnt + c_IDX_W'(1);
                        r_col_cnt <= '0;
                        r_state   <= c_COLLECT;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rpe_weight_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpe_weight_encoder_loader
// Purpose  : Directed self-checking bench for rpe_weight_encoder_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpe_weight_encoder_loader;

    localparam int c_SIZE  = 8;
    localparam int c_CNT_W = $clog2(c_SIZE*c_SIZE+1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  w_valid;
    logic                  w_ready;
    logic [7:0]            w_data;
    logic [c_SIZE*5-1:0]   Weight_out;
    logic                  Weight_out_valid;
    logic                  busy;
    logic                  done;
    logic [c_CNT_W-1:0]    lossy_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int dones    = 0;

    logic [7:0]  wq[$];
    logic [39:0] rq[$];

    rpe_weight_encoder_loader #(.SIZE(c_SIZE)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .w_data           (w_data),
        .Weight_out       (Weight_out),
        .Weight_out_valid (Weight_out_valid),
        .busy             (busy),
        .done             (done),
        .lossy_cnt        (lossy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Even index: multiple of 16 (MSR4 exact); odd index: odd value <= 31 (exact).
    task automatic push_pattern(input int first, input int count);
        logic [39:0] row;
        row = '0;
        for (int k = 0; k < count; k++) begin
            int         i;
            logic [7:0] w;
            logic [4:0] c;
            i = first + k;
            if (i % 2 == 0) begin
                w = 8'((i % 16) * 16);
                c = 5'h10 | 5'(i % 16);
            end else begin
                w = 8'(i & 31);
                c = 5'((i & 31) >> 1);
            end
            wq.push_back(w);
            row[5*(k%8) +: 5] = c;
            if (k % 8 == 7) begin
                rq.push_back(row);
            end
        end
    endtask

    task automatic run_stream(input int n, input bit toggle, input bit want_done);
        int sent;
        bit pend;
        int seen_p;
        bit got_done;
        int cyc;
        bit finished;
        sent = 0; pend = 0; seen_p = 0; got_done = 0; cyc = 0; finished = 0;
        w_valid = 1'b0;
        while (cyc < 400 && !finished) begin
            tick();
            cyc++;
            if (pend) sent++;
            check_eq("valid_timing", Weight_out_valid, (pend && (sent % 8 == 0)));
            if (Weight_out_valid) begin
                if (rq.size() > 0) check_eq("row", Weight_out, rq.pop_front());
                else check_eq("extra_pulse", 1, 0);
                seen_p++;
                pulses++;
            end
            if (done) begin
                dones++;
                got_done = 1;
                check_eq("busy_at_done", busy, 0);
            end
            if (seen_p == n/8 && sent == n && (!want_done || got_done)) begin
                finished = 1;
            end else begin
                w_valid = (sent < n) && (toggle ? (cyc % 2 == 1) : 1'b1);
                w_data  = (sent < n) ? wq[sent] : 8'h00;
                pend    = w_valid && w_ready;
            end
        end
        w_valid = 1'b0;
        check_eq("stream_complete", finished, 1);
        wq.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; w_valid = 1'b1; w_data = 8'hFF;

        // Reset with activity on the inputs
        tick(); tick();
        check_eq("rst_w_ready", w_ready, 0);
        check_eq("rst_wout", Weight_out, 0);
        check_eq("rst_valid", Weight_out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_lossy", lossy_cnt, 0);
        rst = 1'b0; start = 1'b0; w_valid = 1'b0;
        tick();
        check_eq("idle_w_ready", w_ready, 0);

        // Tile 1: exact row, lossy row, then six pattern rows with backpressure
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_ready", w_ready, 1);
        check_eq("start_busy", busy, 1);

        wq = '{8'd0, 8'd16, 8'd240, 8'd1, 8'd31, 8'd17, 8'd3, 8'd144};
        rq.push_back({5'h19, 5'h01, 5'h08, 5'h0F, 5'h00, 5'h1F, 5'h11, 5'h10});
        run_stream(8, 0, 0);
        check_eq("exact_lossy", lossy_cnt, 0);

        wq = '{8'd2, 8'd40, 8'd250, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17};
        rq.push_back({5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h1F, 5'h13, 5'h01});
        run_stream(8, 0, 0);
        check_eq("lossy_cnt3", lossy_cnt, 3);

        push_pattern(16, 48);
        run_stream(48, 1, 1);
        check_eq("tile1_pulses", pulses, 8);
        check_eq("tile1_dones", dones, 1);
        check_eq("tile1_lossy", lossy_cnt, 3);
        tick(); tick(); tick();
        check_eq("idle_after_done", busy, 0);
        check_eq("lossy_holds", lossy_cnt, 3);
        check_eq("no_extra_done", done, 0);

        // Tile 2: start held throughout, toggling valid
        start = 1'b1;
        pulses = 0; dones = 0;
        push_pattern(0, 64);
        run_stream(64, 1, 1);
        check_eq("tile2_pulses", pulses, 8);
        check_eq("tile2_dones", dones, 1);
        check_eq("tile2_lossy", lossy_cnt, 0);
        tick();
        check_eq("restart_idle_busy", busy, 0);
        check_eq("restart_idle_ready", w_ready, 0);
        tick();
        check_eq("restart_ready", w_ready, 1);
        start = 1'b0;

        // Tile 3: two rows plus five weights, then reset mid-row
        push_pattern(0, 16);
        wq[0] = 8'd2;  rq[0][4:0] = 5'h01;
        wq[8] = 8'd40; rq[1][4:0] = 5'h13;
        for (int k = 0; k < 5; k++) wq.push_back(8'(3 + 2*k));
        run_stream(21, 0, 0);
        check_eq("mid_lossy", lossy_cnt, 2);
        rst = 1'b1; w_valid = 1'b1; w_data = 8'd7;
        tick();
        rst = 1'b0; w_valid = 1'b0;
        check_eq("midrst_wout", Weight_out, 0);
        check_eq("midrst_lossy", lossy_cnt, 0);
        check_eq("midrst_busy", busy, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("midrst_no_pulse", Weight_out_valid, 0);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        wq = '{8'd250, 8'd1, 8'd16, 8'd32, 8'd33, 8'd48, 8'd255, 8'd15};
        rq.push_back({5'h07, 5'h1F, 5'h13, 5'h12, 5'h12, 5'h11, 5'h00, 5'h1F});
        run_stream(8, 0, 0);
        check_eq("fresh_lossy", lossy_cnt, 3);
        check_eq("rq_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
